// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared memory port of the multicycle core.
// Owns the 4:1 address/write-data mux select; a grant is held until the
// memory signals done or the hold watchdog expires, and a release with
// pending requests re-arbitrates on the same edge (no idle bubble).
module mem_port_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  // Counter must reach HOLD_MAX-1; keep at least one bit when the watchdog is off.
  localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_EXP = (HOLD_MAX > 0) ? CW'(HOLD_MAX - 1) : '0;
  localparam logic [CW-1:0] CNT_SAT = '1;

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;

  logic          win_vld;
  logic [1:0]    win_idx;
  logic          expire;
  logic          release_port;

  // Rotating search from last+1; walking the offsets downward lets the
  // nearest set bit overwrite farther ones, so the first in order wins.
  always_comb begin
    logic [1:0] idx;
    win_vld = 1'b0;
    win_idx = last_q;
    idx     = last_q;
    for (int i = 3; i >= 0; i--) begin
      idx = last_q + 2'(i + 1);
      if (req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Next-state: done has priority over the watchdog; any release re-arbitrates
  // with the owner as lowest priority because last already points at it.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;

    expire       = (HOLD_MAX != 0) && (state_q == S_GRANT) && !done &&
                   (hold_cnt_q == CNT_EXP);
    release_port = (state_q == S_GRANT) && (done || expire);
    timeout_d    = expire;

    if (state_q == S_GRANT && !release_port && hold_cnt_q != CNT_SAT)
      hold_cnt_d = hold_cnt_q + 1'b1;

    if (state_q == S_IDLE || release_port) begin
      if (win_vld) begin
        state_d    = S_GRANT;
        gnt_d      = 4'b0001 << win_idx;
        sel_d      = win_idx;
        last_d     = win_idx;
        hold_cnt_d = '0;
      end else if (release_port) begin
        state_d    = S_IDLE;
        gnt_d      = 4'b0000;
        hold_cnt_d = '0;
      end
    end

    busy_d = |gnt_d;
  end

  // State and output registers; sel keeps the last winner through idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'b00;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      last_q     <= 2'd3;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (HOLD_MAX = 8). Observed vector is
// {gnt, sel, busy, timeout}; expectations are hand-derived per scenario.
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  logic [7:0] obs;
  int chk;
  int err;

  assign obs = {gnt, sel, busy, timeout};

  mem_port_arbiter #(.HOLD_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // assert/release reset away from the rising edge; last returns to 3
  task automatic do_reset();
    req  = 4'b0000;
    done = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst_n = 1'b0; req = 4'b0000; done = 1'b0;
    #12;
    e = {4'b0000, 2'd0, 1'b0, 1'b0};
    chk++; if (obs !== e) begin err++; $display("FAIL reset_outputs got %b want %b", obs, e); end
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0100;
    step();
    e = {4'b0100, 2'd2, 1'b1, 1'b0};
    chk++; if (obs !== e) begin err++; $display("FAIL single_grant got %b want %b", obs, e); end
    done = 1'b1; req = 4'b0000;
    step();
    done = 1'b0;
    e = {4'b0000, 2'd2, 1'b0, 1'b0};
    chk++; if (obs !== e) begin err++; $display("FAIL release_to_idle got %b want %b", obs, e); end
  endtask

  // last is 2 here; an idle done must not move state, so 1111 then picks 3
  task automatic test_idle_done();
    logic [7:0] e;
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    e = {4'b0000, 2'd2, 1'b0, 1'b0};
    chk++; if (obs !== e) begin err++; $display("FAIL idle_done_ignored got %b want %b", obs, e); end
    req = 4'b1111;
    step();
    e = {4'b1000, 2'd3, 1'b1, 1'b0};
    chk++; if (obs !== e) begin err++; $display("FAIL rotation_after_idle_done got %b want %b", obs, e); end
    req = 4'b0000; done = 1'b1;
    step();
    done = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [7:0] e;
    logic [3:0] one;
    do_reset();
    req = 4'b1111;
    step();
    for (int g = 0; g < 5; g++) begin
      one = 4'b0001 << (g % 4);
      for (int c = 0; c < 3; c++) begin
        e = {one, 2'(g % 4), 1'b1, 1'b0};
        chk++; if (obs !== e) begin err++; $display("FAIL rr_grant%0d_cyc%0d got %b want %b", g, c, obs, e); end
        if (c == 2) done = 1'b1;
        step();
        done = 1'b0;
      end
    end
    req = 4'b0000; done = 1'b1;
    step();
    done = 1'b0;
  endtask

  task automatic test_rotation_skip();
    logic [7:0] e;
    do_reset();
    req = 4'b0010;
    step();
    e = {4'b0010, 2'd1, 1'b1, 1'b0};
    chk++; if (obs !== e) begin err++; $display("FAIL skip_setup got %b want %b", obs, e); end
    req = 4'b0011; done = 1'b1;
    step();
    e = {4'b0001, 2'd0, 1'b1, 1'b0};
    chk++; if (obs !== e) begin err++; $display("FAIL skip_wrap_to_0 got %b want %b", obs, e); end
    step();
    e = {4'b0010, 2'd1, 1'b1, 1'b0};
    chk++; if (obs !== e) begin err++; $display("FAIL skip_next_1 got %b want %b", obs, e); end
    req = 4'b0010;
    step();
    done = 1'b0;
    e = {4'b0010, 2'd1, 1'b1, 1'b0};
    chk++; if (obs !== e) begin err++; $display("FAIL owner_regrant got %b want %b", obs, e); end
    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      step();
      chk++; if (obs !== e) begin err++; $display("FAIL owner_drop_req_cyc%0d got %b want %b", c, obs, e); end
    end
    done = 1'b1;
    step();
    done = 1'b0;
    e = {4'b0000, 2'd1, 1'b0, 1'b0};
    chk++; if (obs !== e) begin err++; $display("FAIL drop_then_done got %b want %b", obs, e); end
  endtask

  task automatic test_watchdog();
    logic [7:0] e;
    do_reset();
    req = 4'b1000;
    step();
    req = 4'b0000;
    e = {4'b1000, 2'd3, 1'b1, 1'b0};
    for (int c = 1; c <= 8; c++) begin
      chk++; if (obs !== e) begin err++; $display("FAIL wd_hold_cyc%0d got %b want %b", c, obs, e); end
      step();
    end
    e = {4'b0000, 2'd3, 1'b0, 1'b1};
    chk++; if (obs !== e) begin err++; $display("FAIL wd_timeout got %b want %b", obs, e); end
    step();
    e = {4'b0000, 2'd3, 1'b0, 1'b0};
    chk++; if (obs !== e) begin err++; $display("FAIL wd_pulse_one_cycle got %b want %b", obs, e); end
    // done in the expiry cycle wins
    req = 4'b1000;
    step();
    req = 4'b0000;
    for (int c = 1; c <= 7; c++) step();
    e = {4'b1000, 2'd3, 1'b1, 1'b0};
    chk++; if (obs !== e) begin err++; $display("FAIL wd2_cyc8 got %b want %b", obs, e); end
    done = 1'b1;
    step();
    done = 1'b0;
    e = {4'b0000, 2'd3, 1'b0, 1'b0};
    chk++; if (obs !== e) begin err++; $display("FAIL wd_done_wins got %b want %b", obs, e); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    do_reset();
    req = 4'b0010;
    step();
    e = {4'b0010, 2'd1, 1'b1, 1'b0};
    chk++; if (obs !== e) begin err++; $display("FAIL mid_setup got %b want %b", obs, e); end
    #2;
    rst_n = 1'b0;
    #1;
    e = {4'b0000, 2'd0, 1'b0, 1'b0};
    chk++; if (obs !== e) begin err++; $display("FAIL async_reset got %b want %b", obs, e); end
    req = 4'b1010;
    #1;
    rst_n = 1'b1;
    step();
    e = {4'b0010, 2'd1, 1'b1, 1'b0};
    chk++; if (obs !== e) begin err++; $display("FAIL post_reset_grant got %b want %b", obs, e); end
  endtask

  initial begin
    chk = 0;
    err = 0;
    test_reset();
    test_idle_done();
    test_round_robin();
    test_rotation_skip();
    test_watchdog();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
